// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the memory stream reader and its output FIFO.
package mem_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int FifoDepth = 2;
    localparam int FifoCntW  = $clog2(FifoDepth + 1);

endpackage

// File: rtl/mem_stream_fifo.sv
// Two-entry first-word-fall-through FIFO; head is visible whenever count is non-zero.
module mem_stream_fifo
    import mem_stream_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_push,
    input  logic [DataWidth-1:0] i_data,
    input  logic                 i_pop,
    output logic [DataWidth-1:0] o_data,
    output logic [FifoCntW-1:0]  o_count,
    output logic                 o_empty
);

    logic [DataWidth-1:0] r_mem [FifoDepth];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [FifoCntW-1:0]  r_count;
    logic                 w_push;
    logic                 w_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FifoCntW'(FifoDepth)) || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FifoDepth; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FifoCntW'(1);
                2'b01:   r_count <= r_count - FifoCntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/mem_stream_reader.sv
// Read-only master: streams len words from a single-port memory starting at base,
// wrapping modulo NumWords, through a 2-entry FIFO to a valid/ready sink.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int NumWords  = 1024,
    parameter int DataWidth = 32,
    parameter int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [AddrWidth-1:0]   base_addr_i,
    input  logic [AddrWidth:0]     len_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    output logic [DataWidth-1:0]   stream_data_o,
    output logic                   stream_valid_o,
    input  logic                   stream_ready_i,
    output logic [1:0]             dbg_state_o
);

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

    state_e                r_state;
    logic [AddrWidth-1:0]  r_addr;
    logic [AddrWidth:0]    r_remaining;
    logic                  r_inflight;
    logic                  r_done;
    logic                  w_issue;
    logic                  w_pop;
    logic                  w_fifo_empty;
    logic                  w_drain_done;
    logic [FifoCntW-1:0]   w_fifo_count;
    logic [FifoCntW:0]     w_occupancy;
    logic [FifoCntW:0]     w_count_next;
    logic [AddrWidth-1:0]  w_addr_next;

    // r_inflight marks a read issued last cycle whose data is on mem_rdata_i now.
    assign w_pop        = stream_valid_o && stream_ready_i;
    assign w_occupancy  = {1'b0, w_fifo_count} + {{FifoCntW{1'b0}}, r_inflight};
    assign w_count_next = w_occupancy - {{FifoCntW{1'b0}}, w_pop};
    assign w_issue      = (r_state == ST_RUN) && (r_remaining != '0)
                          && (w_count_next <= (FifoCntW + 1)'(1));
    assign w_drain_done = (r_state == ST_DRAIN) && (w_count_next == '0);
    assign w_addr_next  = (r_addr == LastAddr) ? '0 : r_addr + AddrWidth'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= w_drain_done;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_addr      <= base_addr_i;
                        r_remaining <= len_i;
                        r_state     <= (len_i == '0) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_addr      <= w_addr_next;
                        r_remaining <= r_remaining - (AddrWidth + 1)'(1);
                        if (r_remaining == (AddrWidth + 1)'(1)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mem_stream_fifo #(
        .DataWidth (DataWidth)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (r_inflight),
        .i_data  (mem_rdata_i),
        .i_pop   (w_pop),
        .o_data  (stream_data_o),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign busy_o         = (r_state != ST_IDLE);
    assign done_o         = r_done;
    assign mem_req_o      = w_issue;
    assign mem_we_o       = 1'b0;
    assign mem_addr_o     = r_addr;
    assign mem_wdata_o    = '0;
    assign mem_be_o       = '0;
    assign stream_valid_o = !w_fifo_empty;
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: random memory image, expected address and beat queues
// built from base/len, cycle-accurate timing checks when the sink is always ready.
module tb_mem_stream_reader;

    localparam int NW = 1024;
    localparam int DW = 32;
    localparam int AW = 10;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            start_i;
    logic [AW-1:0]   base_addr_i;
    logic [AW:0]     len_i;
    logic            busy_o;
    logic            done_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [DW/8-1:0] mem_be_o;
    logic [DW-1:0]   mem_rdata_i;
    logic [DW-1:0]   stream_data_o;
    logic            stream_valid_o;
    logic            stream_ready_i;
    logic [1:0]      dbg_state_o;

    logic [DW-1:0]   mem [NW];
    logic [DW-1:0]   exp_q[$];
    logic [AW-1:0]   exp_addr_q[$];
    int              n_cmp = 0;
    int              n_mis = 0;

    mem_stream_reader #(
        .NumWords  (NW),
        .DataWidth (DW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .len_i          (len_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_o       (mem_be_o),
        .mem_rdata_i    (mem_rdata_i),
        .stream_data_o  (stream_data_o),
        .stream_valid_o (stream_valid_o),
        .stream_ready_i (stream_ready_i),
        .dbg_state_o    (dbg_state_o)
    );

    // clock and memory model: data one cycle after the request, junk otherwise
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        mem_rdata_i <= mem_req_o ? mem[mem_addr_o] : DW'($urandom());
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_quiet(input string ctx);
        check({ctx, "_busy"},  busy_o, 0);
        check({ctx, "_done"},  done_o, 0);
        check({ctx, "_req"},   mem_req_o, 0);
        check({ctx, "_valid"}, stream_valid_o, 0);
    endtask

    task automatic check_all_zero(input string ctx);
        check_quiet(ctx);
        check({ctx, "_we"},    mem_we_o, 0);
        check({ctx, "_addr"},  mem_addr_o, 0);
        check({ctx, "_wdata"}, mem_wdata_o, 0);
        check({ctx, "_be"},    mem_be_o, 0);
        check({ctx, "_data"},  stream_data_o, 0);
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // mode 0: ready always high (exact timing checked), 1: toggling, 2: random.
    task automatic run_transfer(input logic [AW-1:0] base, input int len, input int mode,
                                input bit second_start, input int abort_beats);
        int            cyc;
        int            beats;
        int            last_beat;
        bit            stalled;
        bit            done_seen;
        bit            aborted;
        bit            exp_done;
        logic [DW-1:0] held;
        logic [AW-1:0] a;

        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < len; i++) begin
            a = AW'((int'(base) + i) % NW);
            exp_addr_q.push_back(a);
            exp_q.push_back(mem[a]);
        end

        @(posedge clk_i); #1;
        start_i        = 1'b1;
        base_addr_i    = base;
        len_i          = (AW + 1)'(len);
        stream_ready_i = pick_ready(mode, 0);
        cyc = 0; beats = 0; last_beat = -100;
        stalled = 0; done_seen = 0; aborted = 0; held = '0;

        while (!done_seen && cyc < 4000) begin
            @(negedge clk_i);
            exp_done = (len == 0) ? (cyc == 2) : (beats == len && last_beat == cyc - 1);
            check("done", done_o, exp_done);
            check("busy", busy_o, (cyc >= 1) && !exp_done);
            check("we", mem_we_o, 0);
            check("wdata", mem_wdata_o, 0);
            check("be", mem_be_o, 0);
            check("fifo_cnt_le2", dut.u_fifo.o_count <= 2, 1);
            if (mode == 0) begin
                check("req_timing", mem_req_o, (cyc >= 1) && (cyc <= len));
                check("valid_timing", stream_valid_o, (len > 0) && (cyc >= 3) && (cyc < 3 + len));
            end else if (cyc == 0) begin
                check("req_early", mem_req_o, 0);
            end

            if (exp_addr_q.size() == 0) begin
                check("req_after_last", mem_req_o, 0);
            end else if (mem_req_o) begin
                check("req_addr", mem_addr_o, exp_addr_q.pop_front());
            end

            if (stalled) begin
                check("hold_valid", stream_valid_o, 1);
                check("hold_data", stream_data_o, held);
            end
            if (exp_q.size() == 0) begin
                check("valid_after_last", stream_valid_o, 0);
            end else if (stream_valid_o && stream_ready_i) begin
                check("beat_data", stream_data_o, exp_q.pop_front());
                beats++;
                last_beat = cyc;
            end
            stalled = stream_valid_o && !stream_ready_i;
            held    = stream_data_o;
            if (done_o) done_seen = 1;

            if (abort_beats > 0 && beats == abort_beats) begin
                rst_ni = 1'b0;
                #1;
                check_all_zero("abort");
                #1;
                rst_ni  = 1'b1;
                aborted = 1;
                break;
            end

            @(posedge clk_i); #1;
            cyc++;
            start_i = second_start && (cyc == 2);
            if (start_i) begin
                base_addr_i = AW'($urandom());
                len_i       = (AW + 1)'($urandom_range(1, 20));
            end
            stream_ready_i = pick_ready(mode, cyc);
        end

        start_i = 1'b0;
        if (!aborted) begin
            check("done_seen", done_seen, 1);
            check("beat_count", beats, len);
            check("reqs_left", exp_addr_q.size(), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) mem[i] = DW'($urandom());
        start_i        = 1'b0;
        base_addr_i    = '0;
        len_i          = '0;
        stream_ready_i = 1'b0;
        rst_ni         = 1'b1;
        #1;
        rst_ni = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset_held");
        rst_ni = 1'b1;

        run_transfer(10'h010, 4, 0, 0, 0);
        run_transfer(10'h3FE, 4, 0, 0, 0);
        run_transfer(AW'($urandom()), 8, 1, 0, 0);
        run_transfer(AW'($urandom()), 0, 0, 0, 0);
        run_transfer(AW'($urandom()), 6, 0, 1, 0);
        run_transfer(10'h123, NW, 2, 0, 0);
        for (int k = 0; k < 6; k++) begin
            run_transfer(AW'($urandom()), $urandom_range(1, 40), $urandom_range(0, 2), 0, 0);
        end

        run_transfer(AW'($urandom()), 10, 0, 0, 3);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            check_quiet("post_abort");
        end
        run_transfer(AW'($urandom()), 5, 0, 0, 0);

        repeat (2) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
